// File: rtl/mips_pkg.sv
// mips_pkg: shared stage, instruction-class and write-back encodings for the MIPS control unit
package mips_pkg;
    typedef enum logic [2:0] {ST_FETCH = 3'd0, ST_DECODE, ST_EXEC, ST_MEM, ST_WB} stage_e;
    typedef enum logic [2:0] {CL_ALU, CL_LOAD, CL_STORE, CL_BEQ, CL_BNE, CL_J, CL_JAL, CL_JR} iclass_e;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LOAD    = 6'b100011;
    localparam logic [5:0] OP_STORE   = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    function automatic iclass_e decode_class(input logic [5:0] op, input logic [5:0] fn);
        return op == OP_LOAD  ? CL_LOAD  :
               op == OP_STORE ? CL_STORE :
               op == OP_BEQ   ? CL_BEQ   :
               op == OP_BNE   ? CL_BNE   :
               op == OP_J     ? CL_J     :
               op == OP_JAL   ? CL_JAL   :
               (op == OP_SPECIAL && fn == FN_JR) ? CL_JR : CL_ALU;
    endfunction
endpackage

// File: rtl/mips_npc_calc.sv
// mips_npc_calc: combinational branch compare and next-PC select (assumes 29 <= PC_W <= 32)
module mips_npc_calc
    import mips_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic [2:0]      i_class,
    input  logic [PC_W-1:0] i_pc,
    input  logic [25:0]     i_jtarget,
    input  logic [15:0]     i_imm,
    input  logic [31:0]     i_rs_data,
    input  logic [31:0]     i_rt_data,
    output logic [PC_W-1:0] o_npc
);
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_br;
    logic            w_taken;
    always_comb begin
        w_pc4   = i_pc + PC_W'(4);
        w_br    = w_pc4 + {{(PC_W-18){i_imm[15]}}, i_imm, 2'b00};
        w_taken = (i_class == CL_BEQ && i_rs_data == i_rt_data) ||
                  (i_class == CL_BNE && i_rs_data != i_rt_data);
        o_npc   = w_taken ? w_br :
                  (i_class == CL_J || i_class == CL_JAL) ? {i_pc[PC_W-1:28], i_jtarget, 2'b00} :
                  i_class == CL_JR ? i_rs_data[PC_W-1:0] : w_pc4;
    end
endmodule

// File: rtl/mips_stage_ctrl.sv
// mips_stage_ctrl: multi-cycle stage FSM, PC register and retire/stall counters for the MIPS core
module mips_stage_ctrl
    import mips_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] PC_INIT  = PC_W'(32'h8002_0000),
    parameter int              CNT_W    = 32,
    parameter bit              SKIP_MEM = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [5:0]        i_opcode,
    input  logic [5:0]        i_func,
    input  logic [25:0]       i_jtarget,
    input  logic [15:0]       i_imm,
    input  logic [31:0]       i_rs_data,
    input  logic [31:0]       i_rt_data,
    input  logic              i_im_busy,
    input  logic              i_dm_busy,
    output logic [PC_W-1:0]   o_pc_out,
    output logic              o_im_en,
    output logic              o_ab_load,
    output logic              o_dm_en,
    output logic              o_dm_rd_wr,
    output logic              o_reg_wr_en,
    output logic [1:0]        o_wb_sel,
    output logic [2:0]        o_stage,
    output logic [CNT_W-1:0]  o_retired_cnt,
    output logic [CNT_W-1:0]  o_stall_cnt
);
    stage_e           r_state;
    stage_e           w_next;
    iclass_e          w_class;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_npc;
    logic [PC_W-1:0]  w_npc;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_stall;
    logic             w_mem_op;
    logic             w_wb_op;
    logic             w_wr_op;
    logic             w_stall;
    logic             w_retire;

    mips_npc_calc #(.PC_W(PC_W)) u_npc (
        .i_class   (w_class),
        .i_pc      (r_pc),
        .i_jtarget (i_jtarget),
        .i_imm     (i_imm),
        .i_rs_data (i_rs_data),
        .i_rt_data (i_rt_data),
        .o_npc     (w_npc)
    );

    always_comb begin
        w_class  = decode_class(i_opcode, i_func);
        w_mem_op = w_class == CL_LOAD || w_class == CL_STORE;
        w_wr_op  = w_class == CL_LOAD || w_class == CL_ALU || w_class == CL_JAL;
        w_wb_op  = w_class == CL_ALU || w_class == CL_JAL;
        w_next   = r_state;
        w_stall  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_next  = i_im_busy ? ST_FETCH : ST_DECODE;
                w_stall = i_im_busy;
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = (!SKIP_MEM || w_mem_op) ? ST_MEM : w_wb_op ? ST_WB : ST_FETCH;
            ST_MEM: begin
                w_next  = i_dm_busy ? ST_MEM : (!SKIP_MEM || w_class == CL_LOAD) ? ST_WB : ST_FETCH;
                w_stall = i_dm_busy;
            end
            default:   w_next = ST_FETCH;
        endcase
        // every path back to FETCH from a later stage completes an instruction
        w_retire    = r_state != ST_FETCH && w_next == ST_FETCH;
        o_im_en     = r_state == ST_FETCH && i_reset_n;
        o_ab_load   = r_state == ST_DECODE;
        o_dm_en     = r_state == ST_MEM && w_mem_op;
        o_dm_rd_wr  = !(o_dm_en && w_class == CL_STORE);
        o_reg_wr_en = r_state == ST_WB && w_wr_op;
        o_wb_sel    = r_state != ST_WB ? WB_ALU :
                      w_class == CL_LOAD ? WB_MEM :
                      w_class == CL_JAL  ? WB_PC4 : WB_ALU;
        o_stage       = r_state;
        o_pc_out      = r_pc;
        o_retired_cnt = r_retired;
        o_stall_cnt   = r_stall;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_FETCH;
            r_pc      <= PC_INIT;
            r_npc     <= PC_INIT;
            r_retired <= '0;
            r_stall   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_EXEC)
                r_npc <= w_npc;
            // branches retiring straight out of EXEC have not latched npc yet
            if (w_retire) begin
                r_pc      <= r_state == ST_EXEC ? w_npc : r_npc;
                r_retired <= r_retired + CNT_W'(1);
            end
            if (w_stall)
                r_stall <= r_stall + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mips_stage_ctrl.sv
// tb_mips_stage_ctrl: directed checks of the stage FSM in variable-length and legacy modes
module tb_mips_stage_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  opcode, func;
    logic [25:0] jtarget;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data;
    logic        im_busy, dm_busy;
    logic [31:0] pc_out, retired_cnt, stall_cnt;
    logic        im_en, ab_load, dm_en, dm_rd_wr, reg_wr_en;
    logic [1:0]  wb_sel;
    logic [2:0]  stage;
    logic [31:0] l_pc_out, l_retired_cnt, l_stall_cnt;
    logic        l_im_en, l_ab_load, l_dm_en, l_dm_rd_wr, l_reg_wr_en;
    logic [1:0]  l_wb_sel;
    logic [2:0]  l_stage;
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    mips_stage_ctrl u_dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_opcode(opcode), .i_func(func),
        .i_jtarget(jtarget), .i_imm(imm), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_im_busy(im_busy), .i_dm_busy(dm_busy), .o_pc_out(pc_out), .o_im_en(im_en),
        .o_ab_load(ab_load), .o_dm_en(dm_en), .o_dm_rd_wr(dm_rd_wr), .o_reg_wr_en(reg_wr_en),
        .o_wb_sel(wb_sel), .o_stage(stage), .o_retired_cnt(retired_cnt), .o_stall_cnt(stall_cnt)
    );

    mips_stage_ctrl #(.SKIP_MEM(1'b0)) u_leg (
        .i_clk(clk), .i_reset_n(reset_n), .i_opcode(opcode), .i_func(func),
        .i_jtarget(jtarget), .i_imm(imm), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_im_busy(im_busy), .i_dm_busy(dm_busy), .o_pc_out(l_pc_out), .o_im_en(l_im_en),
        .o_ab_load(l_ab_load), .o_dm_en(l_dm_en), .o_dm_rd_wr(l_dm_rd_wr), .o_reg_wr_en(l_reg_wr_en),
        .o_wb_sel(l_wb_sel), .o_stage(l_stage), .o_retired_cnt(l_retired_cnt), .o_stall_cnt(l_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; opcode = 6'b001001; func = 6'd0; jtarget = 26'd0; imm = 16'd0;
        rs_data = 32'd0; rt_data = 32'd0; im_busy = 1'b0; dm_busy = 1'b0;
        step(); step();
        chk("rst_stage", {29'd0, stage}, 32'd0);
        chk("rst_pc", pc_out, 32'h8002_0000);
        chk("rst_retired", retired_cnt, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_enables", {28'd0, im_en, ab_load, dm_en, reg_wr_en}, 32'd0);
        chk("rst_rd_wr", {31'd0, dm_rd_wr}, 32'd1);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        #1 chk("addiu_fetch_im_en", {31'd0, im_en}, 32'd1);
        step(); chk("addiu_decode_ab", {29'd0, stage, ab_load}, {28'd0, 3'd1, 1'b1});
        step(); chk("addiu_exec_ab", {29'd0, stage, ab_load}, {28'd0, 3'd2, 1'b0});
        step(); chk("addiu_wb", {27'd0, stage, reg_wr_en, wb_sel}, {26'd0, 3'd4, 1'b1, 2'd0});
        step(); chk("addiu_pc", pc_out, 32'h8002_0004);
        chk("addiu_retired", retired_cnt, 32'd1);
        chk("addiu_wr_drop", {29'd0, stage, reg_wr_en}, 32'd0);
        opcode = 6'b100011; dm_busy = 1'b1;
        step(); step(); step();
        chk("lw_mem", {27'd0, stage, dm_en, dm_rd_wr}, {27'd0, 3'd3, 1'b1, 1'b1});
        step(); step();
        chk("lw_mem_held", {29'd0, stage}, 32'd3);
        chk("lw_stall_mid", stall_cnt, 32'd2);
        dm_busy = 1'b0;
        step(); chk("lw_wb", {27'd0, stage, reg_wr_en, wb_sel}, {26'd0, 3'd4, 1'b1, 2'd1});
        step(); chk("lw_pc", pc_out, 32'h8002_0008);
        chk("lw_retired", retired_cnt, 32'd2);
        chk("lw_stall", stall_cnt, 32'd2);
        opcode = 6'b001001;
        repeat (8) step();
        chk("alu_pc_0x10", pc_out, 32'h8002_0010);
        opcode = 6'b000100; rs_data = 32'd5; rt_data = 32'd5; imm = 16'hFFFF;
        step(); step(); chk("beq_exec_no_wr", {29'd0, stage, reg_wr_en}, {28'd0, 3'd2, 1'b0});
        step(); chk("beq_taken_pc", pc_out, 32'h8002_0010);
        chk("beq_stage", {29'd0, stage}, 32'd0);
        chk("beq_retired", retired_cnt, 32'd5);
        rt_data = 32'd6;
        step(); step(); step();
        chk("beq_nt_pc", pc_out, 32'h8002_0014);
        reset_n = 1'b0;
        #1 chk("rst2_pc", pc_out, 32'h8002_0000);
        @(negedge clk) reset_n = 1'b1;
        opcode = 6'b000011; jtarget = 26'h0000040;
        step(); step(); step();
        chk("jal_wb", {27'd0, stage, reg_wr_en, wb_sel}, {26'd0, 3'd4, 1'b1, 2'd2});
        step(); chk("jal_pc", pc_out, 32'h8000_0100);
        opcode = 6'b000000; func = 6'b001000; rs_data = 32'h8002_0100; im_busy = 1'b1;
        step(); chk("im_busy_hold", {29'd0, stage, im_en}, {28'd0, 3'd0, 1'b1});
        chk("im_busy_stall", stall_cnt, 32'd1);
        im_busy = 1'b0;
        step(); step(); step();
        chk("jr_pc", pc_out, 32'h8002_0100);
        chk("jr_retired", retired_cnt, 32'd2);
        opcode = 6'b101011; func = 6'd0; dm_busy = 1'b1;
        step(); step(); step();
        chk("sw_mem", {27'd0, stage, dm_en, dm_rd_wr}, {27'd0, 3'd3, 1'b1, 1'b0});
        step();
        reset_n = 1'b0;
        #1 chk("sw_abort_dm", {30'd0, dm_en, dm_rd_wr}, 32'd1);
        chk("sw_abort_pc", pc_out, 32'h8002_0000);
        chk("sw_abort_cnt", retired_cnt | stall_cnt, 32'd0);
        chk("sw_abort_stage", {29'd0, stage}, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        opcode = 6'b000101; rs_data = 32'd1; rt_data = 32'd1; dm_busy = 1'b0;
        step(); step(); step();
        chk("leg_mem", {27'd0, l_stage, l_dm_en, l_dm_rd_wr}, {27'd0, 3'd3, 1'b0, 1'b1});
        chk("bne_skip_pc", pc_out, 32'h8002_0004);
        step(); chk("leg_wb", {28'd0, l_stage, l_reg_wr_en}, {28'd0, 3'd4, 1'b0});
        step(); chk("leg_pc", l_pc_out, 32'h8002_0004);
        chk("leg_retired", l_retired_cnt, 32'd1);
        chk("leg_stage", {29'd0, l_stage}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
